// File: rtl/parking_gate_sequencer.sv
// Parking gate sequencer.
// Synchronizes and debounces the entry/exit car-presence beams, queues one
// pending request per lane, and runs the request / acknowledge / gate-open /
// clear-wait sequence towards the slot allocator. Exit has priority over entry.
//
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   entry_beam    : raw asynchronous entry-lane beam
//   exit_beam     : raw asynchronous exit-lane beam
//   exit_slot     : slot number presented by the exiting driver
//   door_open     : acknowledge from the slot allocator
//   full          : all-slots-occupied flag from the slot allocator
//   entry_sensor  : one-cycle entry request pulse
//   exit_sensor   : one-cycle exit request pulse
//   switch        : slot being vacated, latched when the exit is selected
//   gate_motor    : gate drive, 1 = open
//   busy          : high whenever the sequencer is not idle
//   denied        : one-cycle pulse when an entry is refused (lot full)
//   timeout_err   : one-cycle pulse when the allocator does not acknowledge
module parking_gate_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES  = 4,
   parameter int unsigned GATE_HOLD_CYCLES = 8,
   parameter int unsigned ACK_TIMEOUT      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_beam,
   input  logic       exit_beam,
   input  logic [1:0] exit_slot,
   input  logic       door_open,
   input  logic       full,
   output logic       entry_sensor,
   output logic       exit_sensor,
   output logic [1:0] switch,
   output logic       gate_motor,
   output logic       busy,
   output logic       denied,
   output logic       timeout_err
);

   localparam int unsigned DEB_W  = 4;
   localparam int unsigned ACK_W  = 4;
   localparam int unsigned HOLD_W = 8;
   localparam int unsigned LANE_ENTRY = 0;
   localparam int unsigned LANE_EXIT  = 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GATE_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REQ        = 3'd1,
      S_WAIT_ACK   = 3'd2,
      S_GATE_OPEN  = 3'd3,
      S_HOLD_CLEAR = 3'd4
   } state_t;

   // Lane-indexed vectors: bit 0 = entry lane, bit 1 = exit lane.
   logic [1:0]            beam_raw;
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0][DEB_W-1:0] dcnt_q, dcnt_d;
   logic [1:0]            rise_c;
   logic [1:0]            pend_q, pend_d;
   logic [1:0]            clr_c;

   state_t                state_q, state_d;
   logic                  lane_q, lane_d;
   logic [ACK_W-1:0]      ack_q, ack_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;

   logic                  entry_sensor_q, entry_sensor_d;
   logic                  exit_sensor_q, exit_sensor_d;
   logic [1:0]            switch_q, switch_d;
   logic                  gate_q, gate_d;
   logic                  busy_q, busy_d;
   logic                  denied_q, denied_d;
   logic                  timeout_q, timeout_d;

   assign beam_raw = {exit_beam, entry_beam};

   // Debouncer: flip the level on the Nth consecutive differing sample.
   always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      rise_c = '0;
      for (int l = 0; l < 2; l++) begin
         if (sync2_q[l] != deb_q[l]) begin
            if (dcnt_q[l] == DEB_LAST) begin
               deb_d[l]  = sync2_q[l];
               rise_c[l] = sync2_q[l];
            end else begin
               dcnt_d[l] = dcnt_q[l] + DEB_W'(1);
            end
         end
      end
   end

   // Pending flags: a clear (only issued while set) wins over a new edge,
   // so an edge arriving while the flag is set is dropped.
   always_comb begin
      pend_d = pend_q;
      for (int l = 0; l < 2; l++) begin
         if (clr_c[l]) begin
            pend_d[l] = 1'b0;
         end else if (rise_c[l]) begin
            pend_d[l] = 1'b1;
         end
      end
   end

   // Sequencer next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      ack_d     = ack_q;
      hold_d    = hold_q;
      switch_d  = switch_q;
      clr_c     = '0;
      denied_d  = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pend_q[LANE_EXIT]) begin
               switch_d         = exit_slot;
               clr_c[LANE_EXIT] = 1'b1;
               lane_d           = 1'b1;
               state_d          = S_REQ;
            end else if (pend_q[LANE_ENTRY]) begin
               clr_c[LANE_ENTRY] = 1'b1;
               if (full) begin
                  denied_d = 1'b1;
               end else begin
                  lane_d  = 1'b0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            ack_d   = '0;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (door_open) begin
               hold_d  = '0;
               state_d = S_GATE_OPEN;
            end else if (ack_q >= ACK_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else if (ack_q != '1) begin
               ack_d = ack_q + ACK_W'(1);
            end
         end
         S_GATE_OPEN: begin
            if (hold_q >= HOLD_LAST) begin
               state_d = S_HOLD_CLEAR;
            end else if (hold_q != '1) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_HOLD_CLEAR: begin
            if (!deb_q[lane_q]) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register with it.
      entry_sensor_d = (state_d == S_REQ) && !lane_d;
      exit_sensor_d  = (state_d == S_REQ) && lane_d;
      gate_d         = (state_d == S_GATE_OPEN) || (state_d == S_HOLD_CLEAR);
      busy_d         = (state_d != S_IDLE);
   end

   // All state, including synchronizers and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         deb_q          <= '0;
         dcnt_q         <= '0;
         pend_q         <= '0;
         state_q        <= S_IDLE;
         lane_q         <= 1'b0;
         ack_q          <= '0;
         hold_q         <= '0;
         entry_sensor_q <= 1'b0;
         exit_sensor_q  <= 1'b0;
         switch_q       <= 2'b00;
         gate_q         <= 1'b0;
         busy_q         <= 1'b0;
         denied_q       <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         sync1_q        <= beam_raw;
         sync2_q        <= sync1_q;
         deb_q          <= deb_d;
         dcnt_q         <= dcnt_d;
         pend_q         <= pend_d;
         state_q        <= state_d;
         lane_q         <= lane_d;
         ack_q          <= ack_d;
         hold_q         <= hold_d;
         entry_sensor_q <= entry_sensor_d;
         exit_sensor_q  <= exit_sensor_d;
         switch_q       <= switch_d;
         gate_q         <= gate_d;
         busy_q         <= busy_d;
         denied_q       <= denied_d;
         timeout_q      <= timeout_d;
      end
   end

   assign entry_sensor = entry_sensor_q;
   assign exit_sensor  = exit_sensor_q;
   assign switch       = switch_q;
   assign gate_motor   = gate_q;
   assign busy         = busy_q;
   assign denied       = denied_q;
   assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Scoreboard bench for parking_gate_sequencer: the driver predicts the
// ordered list of allocator-visible events per transaction, a responder plays
// the slot allocator, and a monitor pops and compares every observed event.
module tb_parking_gate_sequencer;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 8;
   localparam int unsigned ACKT = 4;
   localparam int NOACK = 99;

   localparam logic [2:0] K_ENTRY   = 3'd0;
   localparam logic [2:0] K_EXIT    = 3'd1;
   localparam logic [2:0] K_DENY    = 3'd2;
   localparam logic [2:0] K_TIMEOUT = 3'd3;
   localparam logic [2:0] K_CLOSE   = 3'd4;

   typedef struct packed {
      logic [2:0] kind;
      logic [1:0] slot;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       entry_beam = 1'b0;
   logic       exit_beam = 1'b0;
   logic [1:0] exit_slot = 2'b00;
   logic       door_open = 1'b0;
   logic       full = 1'b0;
   logic       entry_sensor, exit_sensor, gate_motor, busy, denied, timeout_err;
   logic [1:0] switch;

   parking_gate_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .GATE_HOLD_CYCLES(HOLD),
      .ACK_TIMEOUT     (ACKT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .entry_beam  (entry_beam),
      .exit_beam   (exit_beam),
      .exit_slot   (exit_slot),
      .door_open   (door_open),
      .full        (full),
      .entry_sensor(entry_sensor),
      .exit_sensor (exit_sensor),
      .switch      (switch),
      .gate_motor  (gate_motor),
      .busy        (busy),
      .denied      (denied),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   ev_t  exp_q[$];
   int   delay_q[$];
   int   rcnt = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   function automatic ev_t mk(input logic [2:0] k, input logic [1:0] s);
      ev_t e;
      e.kind = k;
      e.slot = s;
      return e;
   endfunction

   function automatic string kname(input logic [2:0] k);
      case (k)
         K_ENTRY:   return "ENTRY";
         K_EXIT:    return "EXIT";
         K_DENY:    return "DENY";
         K_TIMEOUT: return "TIMEOUT";
         K_CLOSE:   return "CLOSE";
         default:   return "?";
      endcase
   endfunction

   // Reference model: what the allocator side should see for one request.
   task automatic expect_req(input bit is_exit, input logic [1:0] slot,
                             input logic fl, input int d);
      if (!is_exit && fl) begin
         exp_q.push_back(mk(K_DENY, 2'b00));
      end else begin
         exp_q.push_back(is_exit ? mk(K_EXIT, slot) : mk(K_ENTRY, 2'b00));
         delay_q.push_back(d);
         if (d < int'(ACKT)) exp_q.push_back(mk(K_CLOSE, 2'b00));
         else                exp_q.push_back(mk(K_TIMEOUT, 2'b00));
      end
   endtask

   task automatic check_ev(input ev_t obs);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL event got=%0s/%0d expected=none at cyc %0d",
                  kname(obs.kind), obs.slot, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e != obs) begin
            failures++;
            $display("FAIL event got=%0s/%0d expected=%0s/%0d at cyc %0d",
                     kname(obs.kind), obs.slot, kname(e.kind), e.slot, cyc);
         end
      end
   endtask

   // Allocator model: acknowledge the n-th request after its planned delay.
   initial begin
      logic rp_en = 1'b0;
      logic rp_ex = 1'b0;
      int   d;
      forever begin
         @(negedge clk);
         door_open = 1'b0;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) door_open = 1'b1;
         end
         if ((entry_sensor && !rp_en) || (exit_sensor && !rp_ex)) begin
            d = (delay_q.size() > 0) ? delay_q.pop_front() : NOACK;
            if (d != NOACK) rcnt = d + 1;
         end
         rp_en = entry_sensor;
         rp_ex = exit_sensor;
      end
   end

   // Monitor: turn output activity into events and check pulse properties.
   initial begin
      logic       pe_en = 1'b0, pe_ex = 1'b0, pe_den = 1'b0, pe_to = 1'b0, pe_gate = 1'b0;
      int         w_en = 0, w_ex = 0, w_den = 0, w_to = 0, gate_w = 0;
      int         last_req = 0;
      logic       in_wait = 1'b0;
      logic [1:0] wait_slot = 2'b00;
      forever begin
         @(negedge clk);
         if (entry_sensor || exit_sensor) begin
            checks++;
            if (entry_sensor && exit_sensor) begin
               failures++;
               $display("FAIL sensor_exclusive got=both expected=one at cyc %0d", cyc);
            end
         end
         if (entry_sensor && !pe_en) begin
            check_ev(mk(K_ENTRY, 2'b00));
            last_req = cyc;
         end
         if (exit_sensor && !pe_ex) begin
            check_ev(mk(K_EXIT, switch));
            last_req  = cyc;
            in_wait   = 1'b1;
            wait_slot = switch;
         end else if (in_wait) begin
            if (gate_motor || timeout_err || !busy) begin
               in_wait = 1'b0;
            end else begin
               checks++;
               if (switch !== wait_slot) begin
                  failures++;
                  $display("FAIL switch_stable got=%0d expected=%0d", switch, wait_slot);
               end
            end
         end
         if (denied && !pe_den) check_ev(mk(K_DENY, 2'b00));
         if (timeout_err && !pe_to) begin
            check_ev(mk(K_TIMEOUT, 2'b00));
            checks++;
            if (cyc != last_req + 1 + int'(ACKT)) begin
               failures++;
               $display("FAIL timeout_latency got=%0d expected=%0d",
                        cyc - last_req, 1 + ACKT);
            end
         end
         if (!gate_motor && pe_gate) begin
            check_ev(mk(K_CLOSE, 2'b00));
            if (!reset) begin
               checks++;
               if (gate_w < int'(HOLD)) begin
                  failures++;
                  $display("FAIL gate_open_time got=%0d expected>=%0d", gate_w, HOLD);
               end
            end
         end
         // one-cycle pulse widths
         if (entry_sensor) w_en++;
         else if (pe_en) begin
            checks++;
            if (w_en != 1) begin failures++; $display("FAIL entry_sensor_width got=%0d expected=1", w_en); end
            w_en = 0;
         end
         if (exit_sensor) w_ex++;
         else if (pe_ex) begin
            checks++;
            if (w_ex != 1) begin failures++; $display("FAIL exit_sensor_width got=%0d expected=1", w_ex); end
            w_ex = 0;
         end
         if (denied) w_den++;
         else if (pe_den) begin
            checks++;
            if (w_den != 1) begin failures++; $display("FAIL denied_width got=%0d expected=1", w_den); end
            w_den = 0;
         end
         if (timeout_err) w_to++;
         else if (pe_to) begin
            checks++;
            if (w_to != 1) begin failures++; $display("FAIL timeout_width got=%0d expected=1", w_to); end
            w_to = 0;
         end
         gate_w  = gate_motor ? gate_w + 1 : 0;
         pe_en   = entry_sensor;
         pe_ex   = exit_sensor;
         pe_den  = denied;
         pe_to   = timeout_err;
         pe_gate = gate_motor;
      end
   end

   // kind: 0 entry, 1 exit, 2 both at once, 3 short glitch on entry beam.
   task automatic run_txn(input int kind, input logic [1:0] slot, input logic fl,
                          input int d_ex, input int d_en, input int h);
      int n;
      @(negedge clk);
      full      = fl;
      exit_slot = slot;
      if (kind == 3) begin
         entry_beam = 1'b1;
         repeat (DEB - 1) @(negedge clk);
         entry_beam = 1'b0;
         repeat (12) @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy got=%b expected=0", busy);
         end
         return;
      end
      if (kind == 1 || kind == 2) expect_req(1'b1, slot, fl, d_ex);
      if (kind == 0 || kind == 2) expect_req(1'b0, 2'b00, fl, d_en);
      entry_beam = (kind != 1);
      exit_beam  = (kind != 0);
      repeat (h) @(negedge clk);
      entry_beam = 1'b0;
      exit_beam  = 1'b0;
      n = 0;
      while (!(exp_q.size() == 0 && !busy && rcnt == 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         failures++;
         $display("FAIL txn_complete got=%0d_pending expected=0", exp_q.size());
         exp_q.delete();
         delay_q.delete();
      end
      repeat (DEB + 4) @(negedge clk);
   endtask

   initial begin
      int n, kind, r, d_ex, d_en;
      repeat (3) @(negedge clk);
      checks++;
      if ({entry_sensor, exit_sensor, switch, gate_motor, busy, denied, timeout_err} !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs got=%b expected=00000000",
                  {entry_sensor, exit_sensor, switch, gate_motor, busy, denied, timeout_err});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(0, 2'b00, 1'b0, 0, 0, 12);          // entry, ack one cycle later
      run_txn(3, 2'b00, 1'b0, 0, 0, 0);           // glitch rejected
      run_txn(1, 2'b10, 1'b0, 1, 0, 15);          // exit slot 2
      run_txn(0, 2'b00, 1'b1, 0, 0, 10);          // lot full -> denied
      run_txn(2, 2'b01, 1'b0, 0, 2, 12);          // both lanes, exit first
      run_txn(1, 2'b11, 1'b0, NOACK, 0, 12);      // no acknowledge
      run_txn(0, 2'b00, 1'b0, 0, int'(ACKT), 8);  // late ack is a timeout
      run_txn(2, 2'b10, 1'b1, 3, 0, 9);           // both, entry denied afterwards

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 3);
         r    = $urandom_range(0, ACKT + 1);
         d_ex = (r < int'(ACKT)) ? r : ((r == int'(ACKT)) ? int'(ACKT) : NOACK);
         r    = $urandom_range(0, ACKT + 1);
         d_en = (r < int'(ACKT)) ? r : ((r == int'(ACKT)) ? int'(ACKT) : NOACK);
         run_txn(kind, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 d_ex, d_en, $urandom_range(DEB + 1, 25));
      end

      // Reset in the middle of the gate-open phase closes the gate at once.
      @(negedge clk);
      full = 1'b0;
      exp_q.push_back(mk(K_ENTRY, 2'b00));
      exp_q.push_back(mk(K_CLOSE, 2'b00));
      delay_q.push_back(0);
      entry_beam = 1'b1;
      n = 0;
      while (!gate_motor && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL gate_open_before_reset got=0 expected=1");
      end
      repeat (3) @(negedge clk);
      reset      = 1'b1;
      entry_beam = 1'b0;
      @(negedge clk);
      checks++;
      if (gate_motor !== 1'b0) begin
         failures++;
         $display("FAIL reset_gate got=%b expected=0", gate_motor);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b expected=0", busy);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (DEB + 8) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_busy got=%b expected=0", busy);
      end

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL events_outstanding got=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parking_gate_sequencer.md
PARKING_GATE_SEQUENCER -- requirements
Module: parking_gate_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive equal raw samples needed to change a debounced beam level (range 2..15).
REQ-002 Parameter GATE_HOLD_CYCLES, default 8: minimum gate-open time in cycles (range 1..255).
REQ-003 Parameter ACK_TIMEOUT, default 4: cycles to wait for door_open after a request pulse (range 2..15).
REQ-004 clk  input  1  single system clock; all logic updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 entry_beam  input  1  raw, asynchronous entry-lane car-presence beam.
REQ-007 exit_beam  input  1  raw, asynchronous exit-lane car-presence beam.
REQ-008 exit_slot  input  2  slot number presented by the exiting driver.
REQ-009 door_open  input  1  acknowledge from the slot allocator.
REQ-010 full  input  1  all-slots-occupied flag from the slot allocator.
REQ-011 entry_sensor  output  1  one-cycle entry request to the allocator.
REQ-012 exit_sensor  output  1  one-cycle exit request to the allocator.
REQ-013 switch  output  2  slot being vacated; valid and stable from the exit_sensor cycle to the end of WAIT_ACK.
REQ-014 gate_motor  output  1  gate drive; 1 = open.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 denied  output  1  one-cycle pulse when an entry is refused because full = 1.
REQ-017 timeout_err  output  1  one-cycle pulse when door_open is not seen within ACK_TIMEOUT.

Function
REQ-018 Each beam shall pass through a 2-flop synchronizer and then a debouncer. The debounced level shall change only after DEBOUNCE_CYCLES consecutive synchronized samples at the new value.
REQ-019 A debounced rising edge shall set that lane's pending flag. The flag shall stay set until the request is serviced, denied or timed out; a second rising edge while the flag is set shall be ignored.
REQ-020 States: IDLE, REQ, WAIT_ACK, GATE_OPEN, HOLD_CLEAR; all outputs shall be registered.
REQ-021 IDLE with exit pending: latch exit_slot into switch, clear the exit pending flag, select the exit lane and go to REQ.
REQ-022 IDLE with both lanes pending: exit shall win; the entry request stays pending for a later cycle.
REQ-023 IDLE with entry pending and full = 1: pulse denied for one cycle, clear the entry pending flag, stay in IDLE.
REQ-024 IDLE with entry pending and full = 0: clear the entry pending flag, select the entry lane and go to REQ.
REQ-025 REQ shall last exactly one cycle, asserting entry_sensor or exit_sensor for the selected lane, then go to WAIT_ACK with the ack counter cleared.
REQ-026 WAIT_ACK with door_open = 1 sampled within ACK_TIMEOUT cycles: go to GATE_OPEN.
REQ-027 WAIT_ACK with no door_open after ACK_TIMEOUT cycles: pulse timeout_err for one cycle and go to IDLE. This covers the allocator ignoring an exit for an empty slot.
REQ-028 GATE_OPEN: gate_motor = 1 for GATE_HOLD_CYCLES cycles, then go to HOLD_CLEAR.
REQ-029 HOLD_CLEAR: gate_motor stays 1 while the selected lane's debounced beam is 1; when it reads 0, drop gate_motor and go to IDLE in the same transition.
REQ-030 Beam edges arriving in any non-IDLE state shall only set pending flags; they shall never interrupt the current sequence.
REQ-031 Counters shall saturate, never wrap. Ack counter: 4 bits. Hold counter: 8 bits.
REQ-032 entry_sensor and exit_sensor shall never be high in the same cycle, and neither shall be high outside REQ.

Reset
REQ-033 While reset = 1 at a clock edge, the block shall load: state IDLE, pending flags 0, debounced levels 0, synchronizers 0, counters 0, all outputs 0 (switch = 2'b00).
REQ-034 Reset asserted mid-sequence shall abort the sequence and close the gate on the next edge. No request pulse shall be issued in the cycle after reset is released.

Verification
REQ-035 Entry, defaults, full = 0: entry_beam held high, door_open returned 1 cycle after entry_sensor -> exactly one entry_sensor pulse, gate_motor high for at least 8 cycles, then low once the debounced beam falls.
REQ-036 Glitch rejection: entry_beam high for 3 cycles then low -> no entry_sensor, busy stays 0.
REQ-037 Exit slot 2: exit_slot = 2'b10, exit_beam held high -> exit_sensor pulse with switch = 2'b10 held through WAIT_ACK; door_open -> gate sequence completes.
REQ-038 Full lot: full = 1, entry beam event -> denied pulse exactly one cycle, no entry_sensor, gate_motor stays 0.
REQ-039 Simultaneous events: both beams rise in the same cycle -> exit serviced first, entry_sensor issued only after return to IDLE.
REQ-040 No acknowledge: door_open held 0 after exit_sensor -> timeout_err pulse 4 cycles after WAIT_ACK entry, return to IDLE. Separately, reset asserted during GATE_OPEN -> gate_motor 0 and busy 0 on the next edge.
